// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction fetch queue with single-outstanding bus requests
// FETCH_BUS_ERROR_EN adds mem_err_i/fetch_fault_o and halts fetch after a faulting word.
module fetch_buffer #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic [31:0]             redirect_pc_i,
  output logic                    mem_req_o,
  output logic [31:0]             mem_addr_o,
  input  logic                    mem_ack_i,
  input  logic [31:0]             mem_data_i,
`ifdef FETCH_BUS_ERROR_EN
  input  logic                    mem_err_i,
  output logic                    fetch_fault_o,
`endif
  output logic                    instr_valid_o,
  input  logic                    instr_ready_i,
  output logic [31:0]             instruction_o,
  output logic [31:0]             pc_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          push, pop, push_fault, halt_q;

`ifdef FETCH_BUS_ERROR_EN
  logic fault_mem [DEPTH];

  assign push_fault = mem_err_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q <= 1'b0;
    end else if (flush_i) begin
      halt_q <= 1'b0;
    end else if (push && mem_err_i) begin
      halt_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fault_mem[wr_q] <= mem_err_i;
  end

  assign fetch_fault_o = instr_valid_o && fault_mem[rd_q];
`else
  assign push_fault = 1'b0;
  assign halt_q     = 1'b0;
`endif

  // Flush wins over both queue ports; the in-flight word is never stored.
  assign push = (state_q == REQ) && mem_ack_i && !flush_i;
  assign pop  = instr_valid_o && instr_ready_i && !flush_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    if (flush_i) begin
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      rd_d       = '0;
      wr_d       = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_d       = wr_q + AW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) rd_d = rd_q + AW'(1);
      if (push && !pop) count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (flush_i || (count_q < FULL && !halt_q)) state_d = REQ;
      end
      REQ: begin
        if (flush_i) state_d = mem_ack_i ? REQ : DISCARD;
        else if (mem_ack_i) state_d = (push_fault || count_d == FULL) ? IDLE : REQ;
      end
      DISCARD: begin
        if (mem_ack_i) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // The bus address only follows fetch_pc when a fresh request starts; DISCARD holds the old one.
  assign addr_d = (state_d == REQ) ? fetch_pc_d : addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_VECTOR;
      addr_q     <= RESET_VECTOR;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]    <= fetch_pc_q;
      instr_mem[wr_q] <= mem_data_i;
    end
  end

  always_comb begin
    mem_req_o     = (state_q != IDLE);
    mem_addr_o    = {addr_q[31:2], 2'b00};
    instr_valid_o = (count_q != '0);
    instruction_o = instr_valid_o ? instr_mem[rd_q] : NOP;
    pc_o          = instr_valid_o ? pc_mem[rd_q] : 32'h0;
    count_o       = count_q;
  end

endmodule
